// File: rtl/demux32_1to3_reg_if.sv
// Handshake bundle for the registered 1-to-3 demultiplexer: one producer
// stream in, three consumer streams out, plus the drop/error reporting.
interface demux32_1to3_reg_if #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_sel;

   logic             out0_valid;
   logic             out0_ready;
   logic [WIDTH-1:0] out0_data;
   logic             out1_valid;
   logic             out1_ready;
   logic [WIDTH-1:0] out1_data;
   logic             out2_valid;
   logic             out2_ready;
   logic [WIDTH-1:0] out2_data;

   logic             err;
   logic [CNTW-1:0]  drop_cnt;
   logic             err_clr;

   // master is the environment (producer + consumers), slave is the demux
   modport master (
      output in_valid, in_data, in_sel, err_clr,
      output out0_ready, out1_ready, out2_ready,
      input  in_ready, err, drop_cnt,
      input  out0_valid, out0_data, out1_valid, out1_data, out2_valid, out2_data
   );

   modport slave (
      input  in_valid, in_data, in_sel, err_clr,
      input  out0_ready, out1_ready, out2_ready,
      output in_ready, err, drop_cnt,
      output out0_valid, out0_data, out1_valid, out1_data, out2_valid, out2_data
   );
endinterface

// File: rtl/demux32_1to3_reg.sv
// Registered 1-to-3 demultiplexer: each destination owns a one-entry buffer,
// illegal-select words are dropped and counted with a saturating counter.
module demux32_1to3_reg #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   demux32_1to3_reg_if.slave    bus
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

   chan_state_t      state0, state1, state2;
   logic [WIDTH-1:0] data0, data1, data2;
   logic             err_q;
   logic [CNTW-1:0]  cnt_q;
   logic             ready;
   logic             accept;
   logic             take0, take1, take2, take_bad;

   // A full channel can still accept when its consumer drains in the same cycle
   always_comb begin
      ready = 1'b1;
      unique case (bus.in_sel)
         2'd0:    ready = (state0 == EMPTY) || bus.out0_ready;
         2'd1:    ready = (state1 == EMPTY) || bus.out1_ready;
         2'd2:    ready = (state2 == EMPTY) || bus.out2_ready;
         default: ready = 1'b1;
      endcase
   end

   assign accept   = bus.in_valid && ready;
   assign take0    = accept && (bus.in_sel == 2'd0);
   assign take1    = accept && (bus.in_sel == 2'd1);
   assign take2    = accept && (bus.in_sel == 2'd2);
   assign take_bad = accept && (bus.in_sel == 2'd3);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state0 <= EMPTY;
         state1 <= EMPTY;
         state2 <= EMPTY;
         data0  <= '0;
         data1  <= '0;
         data2  <= '0;
         err_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         if (take0) begin
            data0  <= bus.in_data;
            state0 <= FULL;
         end else if ((state0 == FULL) && bus.out0_ready) begin
            state0 <= EMPTY;
         end

         if (take1) begin
            data1  <= bus.in_data;
            state1 <= FULL;
         end else if ((state1 == FULL) && bus.out1_ready) begin
            state1 <= EMPTY;
         end

         if (take2) begin
            data2  <= bus.in_data;
            state2 <= FULL;
         end else if ((state2 == FULL) && bus.out2_ready) begin
            state2 <= EMPTY;
         end

         // Clear has priority over a simultaneous drop; the counter never wraps
         if (bus.err_clr) begin
            err_q <= 1'b0;
            cnt_q <= '0;
         end else if (take_bad) begin
            err_q <= 1'b1;
            if (cnt_q != {CNTW{1'b1}})
               cnt_q <= cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
         end
      end
   end

   assign bus.in_ready   = ready;
   assign bus.out0_valid = (state0 == FULL);
   assign bus.out1_valid = (state1 == FULL);
   assign bus.out2_valid = (state2 == FULL);
   assign bus.out0_data  = data0;
   assign bus.out1_data  = data1;
   assign bus.out2_data  = data2;
   assign bus.err        = err_q;
   assign bus.drop_cnt   = cnt_q;
endmodule
